// File: rtl/pipeline_ctrl.sv
// Stall/flush/halt sequencer for the 5-stage pipeline: merges load-use, MDU occupancy,
// data-memory wait and taken-branch conditions into per-stage controls, plus drain/halt.
//
// state    | meaning
// RUN      | normal issue; hazards resolved per cycle
// MDU_BUSY | multiply/divide occupying EX, front end and EX held
// DRAIN    | halt requested, fetch squashed until the pipe empties
// HALTED   | pipeline idle, waiting for halt_req_i to drop
module pipeline_ctrl #(
  parameter int MDU_CYCLES   = 32,
  parameter int DRAIN_CYCLES = 4,
  parameter int CNT_W        = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             ID_EX_MemRead_i,
  input  logic [4:0]       ID_EX_RegisterRt_i,
  input  logic [4:0]       IF_ID_RS_i,
  input  logic [4:0]       IF_ID_RT_i,
  input  logic             branch_taken_i,
  input  logic             mdu_start_i,
  input  logic             dmem_req_i,
  input  logic             dmem_ack_i,
  input  logic             halt_req_i,
  output logic             pc_write_o,
  output logic             if_id_write_o,
  output logic             id_ex_write_o,
  output logic             ex_mem_write_o,
  output logic             mem_wb_write_o,
  output logic             if_id_flush_o,
  output logic             ctrl_sel_o,
  output logic             ex_bubble_o,
  output logic             halted_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  localparam int MW = (MDU_CYCLES > 2) ? $clog2(MDU_CYCLES) : 1;
  localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  typedef enum logic [1:0] {RUN, MDU_BUSY, DRAIN, HALTED} state_t;

  state_t           state_q, state_d;
  logic [MW-1:0]    mdu_cnt_q, mdu_cnt_d;
  logic [DW-1:0]    drain_cnt_q, drain_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic load_use, mem_freeze, mdu_stall, advancing;

  assign load_use   = ID_EX_MemRead_i && (ID_EX_RegisterRt_i != 5'd0) &&
                      ((ID_EX_RegisterRt_i == IF_ID_RS_i) || (ID_EX_RegisterRt_i == IF_ID_RT_i));
  assign mem_freeze = dmem_req_i && !dmem_ack_i;
  assign mdu_stall  = (state_q == MDU_BUSY) || ((state_q == RUN) && mdu_start_i);

  // Priority-ordered stage controls; the first matching condition wins.
  always_comb begin
    pc_write_o     = 1'b1;
    if_id_write_o  = 1'b1;
    id_ex_write_o  = 1'b1;
    ex_mem_write_o = 1'b1;
    mem_wb_write_o = 1'b1;
    if_id_flush_o  = 1'b0;
    ctrl_sel_o     = 1'b1;
    ex_bubble_o    = 1'b0;
    advancing      = 1'b1;
    if (mem_freeze) begin
      pc_write_o     = 1'b0;
      if_id_write_o  = 1'b0;
      id_ex_write_o  = 1'b0;
      ex_mem_write_o = 1'b0;
      mem_wb_write_o = 1'b0;
      advancing      = 1'b0;
    end else if (mdu_stall) begin
      pc_write_o    = 1'b0;
      if_id_write_o = 1'b0;
      id_ex_write_o = 1'b0;
      ex_bubble_o   = 1'b1;
      advancing     = 1'b0;
    end else if (load_use && ((state_q == RUN) || (state_q == DRAIN))) begin
      pc_write_o    = 1'b0;
      if_id_write_o = 1'b0;
      ctrl_sel_o    = 1'b0;
      advancing     = 1'b0;
    end else if (state_q == DRAIN) begin
      if_id_flush_o = 1'b1;
      pc_write_o    = branch_taken_i;
    end else if (state_q == HALTED) begin
      pc_write_o    = 1'b0;
      if_id_flush_o = 1'b1;
    end else if (branch_taken_i && (state_q == RUN)) begin
      if_id_flush_o = 1'b1;
    end
  end

  always_comb begin
    state_d     = state_q;
    mdu_cnt_d   = mdu_cnt_q;
    drain_cnt_d = drain_cnt_q;
    stall_cnt_d = stall_cnt_q;
    unique case (state_q)
      RUN: begin
        if (mdu_start_i) begin
          state_d   = MDU_BUSY;
          mdu_cnt_d = MW'(MDU_CYCLES - 1);
        end else if (halt_req_i && advancing) begin
          state_d     = DRAIN;
          drain_cnt_d = DW'(DRAIN_CYCLES - 1);
        end
      end
      MDU_BUSY: begin
        // The MDU keeps running through memory freezes, so count unconditionally.
        if (mdu_cnt_q == MW'(1)) begin
          state_d   = RUN;
          mdu_cnt_d = '0;
        end else begin
          mdu_cnt_d = mdu_cnt_q - MW'(1);
        end
      end
      DRAIN: begin
        if (advancing) begin
          if (drain_cnt_q == '0) state_d = HALTED;
          else drain_cnt_d = drain_cnt_q - DW'(1);
        end
      end
      HALTED: begin
        if (!halt_req_i) state_d = RUN;
      end
      default: state_d = RUN;
    endcase
    if (((state_q == RUN) || (state_q == MDU_BUSY)) && !pc_write_o && (stall_cnt_q != '1))
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= RUN;
      mdu_cnt_q   <= '0;
      drain_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      mdu_cnt_q   <= mdu_cnt_d;
      drain_cnt_q <= drain_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign halted_o    = (state_q == HALTED);
  assign stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: directed scenarios plus randomized traffic
// compared against a countdown-based reference model. Narrow stall counter keeps saturation short.
module tb_pipeline_ctrl;
  localparam int MDU_CYCLES   = 32;
  localparam int DRAIN_CYCLES = 4;
  localparam int CNT_W        = 8;
  localparam int CNT_MAX      = (1 << CNT_W) - 1;

  // {pc, if_id, id_ex, ex_mem, mem_wb, flush, ctrl_sel, bubble, halted}
  localparam logic [8:0] P_DEF   = 9'b11111_0_1_0_0;
  localparam logic [8:0] P_LU    = 9'b00111_0_0_0_0;
  localparam logic [8:0] P_MDU   = 9'b00011_0_1_1_0;
  localparam logic [8:0] P_FRZ   = 9'b00000_0_1_0_0;
  localparam logic [8:0] P_BR    = 9'b11111_1_1_0_0;
  localparam logic [8:0] P_DRN   = 9'b01111_1_1_0_0;
  localparam logic [8:0] P_HLT   = 9'b01111_1_1_0_1;

  logic clk = 1'b0, rst = 1'b1;
  logic memread, branch, start, req, ack, halt;
  logic [4:0] ex_rt, id_rs, id_rt;
  logic pc_w, ifid_w, idex_w, exmem_w, memwb_w, flush, csel, bub, halted;
  logic [CNT_W-1:0] scnt;
  logic [8:0] obs;

  int checks = 0, errors = 0;

  // reference model: remaining cycles of each activity
  int m_mdu_left, m_drain_left, m_stall;
  bit m_halted, m_run, m_inmdu, m_adv;
  logic [8:0] exp_v;
  logic [CNT_W-1:0] exp_cnt;

  always #5 clk = ~clk;

  assign obs = {pc_w, ifid_w, idex_w, exmem_w, memwb_w, flush, csel, bub, halted};

  pipeline_ctrl #(.MDU_CYCLES(MDU_CYCLES), .DRAIN_CYCLES(DRAIN_CYCLES), .CNT_W(CNT_W)) dut (
    .clk_i(clk), .rst_i(rst),
    .ID_EX_MemRead_i(memread), .ID_EX_RegisterRt_i(ex_rt),
    .IF_ID_RS_i(id_rs), .IF_ID_RT_i(id_rt),
    .branch_taken_i(branch), .mdu_start_i(start),
    .dmem_req_i(req), .dmem_ack_i(ack), .halt_req_i(halt),
    .pc_write_o(pc_w), .if_id_write_o(ifid_w), .id_ex_write_o(idex_w),
    .ex_mem_write_o(exmem_w), .mem_wb_write_o(memwb_w),
    .if_id_flush_o(flush), .ctrl_sel_o(csel), .ex_bubble_o(bub),
    .halted_o(halted), .stall_cnt_o(scnt)
  );

  task automatic set_idle();
    memread = 0; ex_rt = 0; id_rs = 0; id_rt = 0;
    branch = 0; start = 0; req = 0; ack = 0; halt = 0;
  endtask

  task automatic model_reset();
    m_mdu_left = 0; m_drain_left = 0; m_stall = 0; m_halted = 0;
  endtask

  task automatic model_eval();
    bit lu, frz, ms, drn;
    bit pc, ifid, idex, exmem, memwb, fl, cs, bb;
    m_inmdu = (m_mdu_left > 0);
    drn     = (m_drain_left > 0);
    m_run   = !m_inmdu && !drn && !m_halted;
    lu  = memread && (ex_rt != 0) && ((ex_rt == id_rs) || (ex_rt == id_rt));
    frz = req && !ack;
    ms  = m_inmdu || (m_run && start);
    {pc, ifid, idex, exmem, memwb, fl, cs, bb} = 8'b11111_0_1_0;
    m_adv = 1;
    if (frz) begin {pc, ifid, idex, exmem, memwb} = 5'b0; m_adv = 0; end
    else if (ms) begin {pc, ifid, idex} = 3'b0; bb = 1; m_adv = 0; end
    else if (lu && (m_run || drn)) begin {pc, ifid, cs} = 3'b0; m_adv = 0; end
    else if (drn) begin fl = 1; pc = branch; end
    else if (m_halted) begin pc = 0; fl = 1; end
    else if (branch) fl = 1;
    exp_v   = {pc, ifid, idex, exmem, memwb, fl, cs, bb, m_halted};
    exp_cnt = CNT_W'(m_stall);
  endtask

  task automatic model_commit();
    if ((m_run || m_inmdu) && !exp_v[8] && (m_stall < CNT_MAX)) m_stall++;
    if (m_run) begin
      if (start) m_mdu_left = MDU_CYCLES - 1;
      else if (halt && m_adv) m_drain_left = DRAIN_CYCLES;
    end else if (m_inmdu) m_mdu_left--;
    else if (m_drain_left > 0) begin
      if (m_adv) begin
        m_drain_left--;
        if (m_drain_left == 0) m_halted = 1;
      end
    end else if (!halt) m_halted = 0;
  endtask

  task automatic eval_cycle();
    @(negedge clk);
    model_eval();
  endtask

  task automatic next_cycle();
    model_commit();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    set_idle();
    rst = 1;
    @(posedge clk);
    @(negedge clk);
    rst = 0;
    model_reset();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    eval_cycle();
    checks++;
    if (obs !== P_DEF || scnt !== '0) begin
      errors++;
      $display("FAIL reset_defaults: got %b cnt %0d want %b cnt 0", obs, scnt, P_DEF);
    end
    next_cycle();
  endtask

  task automatic test_load_use();
    logic [8:0] want [4] = '{P_LU, P_DEF, P_DEF, P_LU};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      set_idle();
      case (i)
        0: begin memread = 1; ex_rt = 5; id_rs = 5; id_rt = 9; end
        2: begin memread = 1; ex_rt = 0; id_rs = 0; id_rt = 0; end
        3: begin memread = 1; ex_rt = 7; id_rs = 1; id_rt = 7; end
        default: ;
      endcase
      eval_cycle();
      checks++;
      if (obs !== want[i]) begin
        errors++;
        $display("FAIL load_use step %0d: got %b want %b", i, obs, want[i]);
      end
      next_cycle();
    end
    set_idle();
    eval_cycle();
    checks++;
    if (scnt !== CNT_W'(2)) begin
      errors++;
      $display("FAIL load_use_count: got %0d want 2", scnt);
    end
    next_cycle();
  endtask

  task automatic test_mdu(input bit with_freeze);
    logic [8:0] want;
    do_reset();
    for (int i = 0; i < 34; i++) begin
      set_idle();
      start = (i == 0);
      if (with_freeze) begin
        req = (i >= 5 && i <= 8);
        ack = (i == 8);
      end
      want = (with_freeze && i >= 5 && i <= 7) ? P_FRZ : (i < MDU_CYCLES) ? P_MDU : P_DEF;
      eval_cycle();
      checks++;
      if (obs !== want) begin
        errors++;
        $display("FAIL mdu%s cyc %0d: got %b want %b", with_freeze ? "_freeze" : "", i, obs, want);
      end
      if (i == 33) begin
        checks++;
        if (scnt !== CNT_W'(MDU_CYCLES)) begin
          errors++;
          $display("FAIL mdu_stall_count: got %0d want %0d", scnt, MDU_CYCLES);
        end
      end
      next_cycle();
    end
  endtask

  task automatic test_branch();
    do_reset();
    set_idle();
    branch = 1;
    eval_cycle();
    checks++;
    if (obs !== P_BR) begin
      errors++;
      $display("FAIL branch_flush: got %b want %b", obs, P_BR);
    end
    next_cycle();
    memread = 1; ex_rt = 3; id_rs = 3;
    eval_cycle();
    checks++;
    if (obs !== P_LU) begin
      errors++;
      $display("FAIL branch_vs_load_use: got %b want %b", obs, P_LU);
    end
    next_cycle();
  endtask

  task automatic test_halt();
    logic [8:0] want;
    do_reset();
    for (int i = 0; i < 10; i++) begin
      set_idle();
      halt = (i < 8);
      req  = (i == 2 || i == 4);
      branch = (i == 5);
      if (i == 0) want = P_DEF;
      else if (i == 2 || i == 4) want = P_FRZ;
      else if (i == 5) want = P_BR;
      else if (i <= 6) want = P_DRN;
      else if (i <= 8) want = P_HLT;
      else want = P_DEF;
      eval_cycle();
      checks++;
      if (obs !== want) begin
        errors++;
        $display("FAIL halt_seq cyc %0d: got %b want %b", i, obs, want);
      end
      next_cycle();
    end
  endtask

  task automatic test_reset_mid_mdu();
    do_reset();
    for (int i = 0; i < 22; i++) begin
      set_idle();
      start = (i == 0);
      eval_cycle();
      next_cycle();
    end
    eval_cycle();
    rst = 1;
    #1;
    checks++;
    if (obs !== P_DEF || scnt !== '0) begin
      errors++;
      $display("FAIL reset_mid_mdu: got %b cnt %0d want %b cnt 0", obs, scnt, P_DEF);
    end
    do_reset();
    eval_cycle();
    checks++;
    if (obs !== P_DEF) begin
      errors++;
      $display("FAIL after_reset_mid_mdu: got %b want %b", obs, P_DEF);
    end
    next_cycle();
  endtask

  task automatic test_saturation();
    do_reset();
    req = 1; ack = 0;
    for (int i = 0; i < CNT_MAX + 40; i++) begin
      eval_cycle();
      next_cycle();
    end
    eval_cycle();
    checks++;
    if (obs !== P_FRZ || scnt !== CNT_W'(CNT_MAX)) begin
      errors++;
      $display("FAIL saturate: got %b cnt %0d want %b cnt %0d", obs, scnt, P_FRZ, CNT_MAX);
    end
    next_cycle();
    set_idle();
    eval_cycle();
    next_cycle();
    eval_cycle();
    checks++;
    if (scnt !== CNT_W'(CNT_MAX)) begin
      errors++;
      $display("FAIL saturate_hold: got %0d want %0d", scnt, CNT_MAX);
    end
    next_cycle();
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      memread = 1'($urandom_range(0, 1));
      ex_rt   = 5'($urandom_range(0, 3));
      id_rs   = 5'($urandom_range(0, 3));
      id_rt   = 5'($urandom_range(0, 3));
      branch  = ($urandom_range(0, 3) == 0);
      start   = ($urandom_range(0, 24) == 0);
      req     = ($urandom_range(0, 3) == 0);
      ack     = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 11) == 0) halt = ~halt;
      eval_cycle();
      checks++;
      if (obs !== exp_v || scnt !== exp_cnt) begin
        errors++;
        $display("FAIL random cyc %0d: got %b cnt %0d want %b cnt %0d", i, obs, scnt, exp_v, exp_cnt);
      end
      next_cycle();
    end
  endtask

  initial begin
    set_idle();
    model_reset();
    test_reset();
    test_load_use();
    test_mdu(1'b0);
    test_mdu(1'b1);
    test_branch();
    test_halt();
    test_reset_mid_mdu();
    test_saturation();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
